// File: rtl/lut_init_readback_pkg.sv
// Shared types and sizes for the LUT INIT readback engine.
package lut_init_readback_pkg;

    localparam int LUT_MAX_WIDTH = 4;
    localparam int INIT_BITS     = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } rb_state_t;

endpackage

// File: rtl/lut_readback_ctrl.sv
// Readback sequencer: FSM with address index and settle-wait counters.
module lut_readback_ctrl
    import lut_init_readback_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             accept,
    output logic             sample,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] idx
);

    localparam logic [2:0]       SETTLE_C = 3'(SETTLE);
    localparam logic [WIDTH-1:0] IDX_MAX  = '1;

    rb_state_t        state_q, state_d;
    logic [2:0]       wait_q;
    logic [WIDTH-1:0] idx_q;

    assign accept = (state_q == IDLE) && start;
    assign sample = (state_q == SAMPLE);
    assign last   = (idx_q == IDX_MAX);
    assign busy   = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done   = (state_q == DONE);
    assign idx    = idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wait_q <= 3'd0;
                idx_q  <= '0;
            end else if (state_q == DRIVE && wait_q != SETTLE_C) begin
                wait_q <= wait_q + 3'd1;
            end else if (sample && !last) begin
                wait_q <= 3'd0;
                idx_q  <= idx_q + WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (wait_q == SETTLE_C) state_d = SAMPLE;
            SAMPLE:  state_d = last ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/lut_init_readback.sv
// LUT truth-table readback: walks lut_a over every address and rebuilds INIT.
// Define LUT_READBACK_CHECK_EN to compare the recovered INIT against exp_init.
module lut_init_readback
    import lut_init_readback_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     C,
    input  logic                     R,
    input  logic                     start,
    output logic [LUT_MAX_WIDTH-1:0] lut_a,
    input  logic                     lut_o,
    input  logic [INIT_BITS-1:0]     exp_init,
    output logic                     busy,
    output logic                     done,
    output logic [INIT_BITS-1:0]     init_out,
    output logic                     match
);

    if (WIDTH < 1 || WIDTH > LUT_MAX_WIDTH) begin : g_bad_width
        $error("lut_init_readback: WIDTH must be in 1..4");
    end
    if (SETTLE < 0 || SETTLE > 7) begin : g_bad_settle
        $error("lut_init_readback: SETTLE must be in 0..7");
    end

    logic                 accept;
    logic                 sample;
    logic                 last;
    logic [WIDTH-1:0]     idx;
    logic [INIT_BITS-1:0] init_next;

    lut_readback_ctrl #(
        .WIDTH (WIDTH),
        .SETTLE(SETTLE)
    ) u_ctrl (
        .clk   (C),
        .rst   (R),
        .start (start),
        .accept(accept),
        .sample(sample),
        .last  (last),
        .busy  (busy),
        .done  (done),
        .idx   (idx)
    );

    // The word as it will look once the current sample lands.
    always_comb begin
        init_next      = init_out;
        init_next[idx] = lut_o;
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            lut_a    <= '0;
            init_out <= '0;
        end else if (accept) begin
            lut_a    <= '0;
            init_out <= '0;
        end else if (sample) begin
            init_out <= init_next;
            if (!last) lut_a <= LUT_MAX_WIDTH'(idx) + LUT_MAX_WIDTH'(1);
        end
    end

`ifdef LUT_READBACK_CHECK_EN
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            match <= 1'b0;
        end else if (accept) begin
            match <= 1'b0;
        end else if (sample && last) begin
            match <= (init_next == exp_init);
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^exp_init;
    assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_lut_init_readback.sv
// Bench for lut_init_readback: three parameterisations against a
// cycle-count model of the readback sequence, plus literal checks.
module tb_lut_init_readback;

`ifdef LUT_READBACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int NI = 3;
    localparam int W_P[NI] = '{4, 2, 1};
    localparam int S_P[NI] = '{0, 1, 3};

    logic        C = 1'b0;
    logic        R = 1'b1;
    logic        st[NI];
    logic [3:0]  la[NI];
    logic        lo[NI];
    logic [15:0] ex[NI];
    logic        bz[NI];
    logic        dn[NI];
    logic [15:0] io[NI];
    logic        mt[NI];
    logic [15:0] lut_init[NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 C = ~C;

    // Behavioural LUT primitives sitting on each DUT's address pins.
    assign lo[0] = lut_init[0][la[0]];
    assign lo[1] = lut_init[1][la[1]];
    assign lo[2] = lut_init[2][la[2]];

    lut_init_readback #(.WIDTH(4), .SETTLE(0)) u_w4 (
        .C(C), .R(R), .start(st[0]), .lut_a(la[0]), .lut_o(lo[0]),
        .exp_init(ex[0]), .busy(bz[0]), .done(dn[0]),
        .init_out(io[0]), .match(mt[0]));

    lut_init_readback #(.WIDTH(2), .SETTLE(1)) u_w2 (
        .C(C), .R(R), .start(st[1]), .lut_a(la[1]), .lut_o(lo[1]),
        .exp_init(ex[1]), .busy(bz[1]), .done(dn[1]),
        .init_out(io[1]), .match(mt[1]));

    lut_init_readback #(.WIDTH(1), .SETTLE(3)) u_w1 (
        .C(C), .R(R), .start(st[2]), .lut_a(la[2]), .lut_o(lo[2]),
        .exp_init(ex[2]), .busy(bz[2]), .done(dn[2]),
        .init_out(io[2]), .match(mt[2]));

    function automatic int tot(input int i);
        return (1 << W_P[i]) * (S_P[i] + 2);
    endfunction

    function automatic logic [15:0] mask(input int n);
        if (n >= 16) return 16'hFFFF;
        return 16'((32'd1 << n) - 32'd1);
    endfunction

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s inst%0d at %0t: got %h want %h",
                     nm, inst, $time, act, req);
        end
    endtask

    // Model: k = edges since the accepting edge; one slot per S+2 edges.
    bit          run[NI];
    int          k[NI];
    logic [15:0] cap[NI];
    logic [15:0] m_init[NI];
    logic        m_match[NI];
    logic [3:0]  m_la[NI];

    always @(posedge C or posedge R) begin
        for (int i = 0; i < NI; i++) begin
            if (R) begin
                run[i] = 0; k[i] = 0; m_init[i] = '0;
                m_match[i] = 1'b0; m_la[i] = '0;
            end else if (!run[i]) begin
                if (st[i]) begin
                    run[i] = 1; k[i] = 0; cap[i] = lut_init[i];
                    m_init[i] = '0; m_match[i] = 1'b0; m_la[i] = '0;
                end
            end else begin
                k[i]++;
                if (k[i] > tot(i)) begin
                    run[i] = 0;
                end else begin
                    int n;
                    int nmax;
                    n = k[i] / (S_P[i] + 2);
                    nmax = 1 << W_P[i];
                    m_init[i] = cap[i] & mask(n);
                    m_la[i] = 4'((n < nmax) ? n : nmax - 1);
                    if (k[i] == tot(i))
                        m_match[i] = CHECK_EN && (m_init[i] == ex[i]);
                end
            end
        end
    end

    always @(negedge C) begin
        for (int i = 0; i < NI; i++) begin
            chk("busy", i, 32'(bz[i]), 32'(run[i] && k[i] < tot(i)));
            chk("done", i, 32'(dn[i]), 32'(run[i] && k[i] == tot(i)));
            chk("lut_a", i, 32'(la[i]), 32'(m_la[i]));
            chk("init_out", i, 32'(io[i]), 32'(m_init[i]));
            chk("match", i, 32'(mt[i]), 32'(m_match[i]));
        end
    end

    task automatic pulse_start(input int i);
        @(negedge C); st[i] = 1'b1;
        @(negedge C); st[i] = 1'b0;
    endtask

    // Counts negedges from the one after the accepting edge until done.
    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        while (dn[i] !== 1'b1 && cyc < 400) begin
            @(negedge C); cyc++;
        end
        if (dn[i] !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout inst%0d: no done within %0d cycles", i, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0; ex[i] = '0; lut_init[i] = '0;
        end
        repeat (3) @(negedge C);
        chk("rst_busy", 0, 32'(bz[0]), 0);
        chk("rst_init", 1, 32'(io[1]), 0);
        chk("rst_lut_a", 2, 32'(la[2]), 0);
        R = 1'b0;
        repeat (2) @(negedge C);

        // OR2, settle 1
        lut_init[1] = 16'h000E; ex[1] = 16'h000E;
        pulse_start(1); wait_done(1, cyc);
        chk("t1_cycles", 1, 32'(cyc), 12);
        chk("t1_init", 1, 32'(io[1]), 32'h000E);
        chk("t1_match", 1, 32'(mt[1]), 32'(CHECK_EN));

        // AND4, settle 0
        lut_init[0] = 16'h8000; ex[0] = 16'h8000;
        pulse_start(0); wait_done(0, cyc);
        chk("t2_cycles", 0, 32'(cyc), 32);
        chk("t2_init", 0, 32'(io[0]), 32'h8000);
        chk("t2_lut_a", 0, 32'(la[0]), 15);
        chk("t2_match", 0, 32'(mt[0]), 32'(CHECK_EN));

        // inverter, width 1, settle 3
        lut_init[2] = 16'h0001; ex[2] = 16'h0001;
        pulse_start(2); wait_done(2, cyc);
        chk("t3_cycles", 2, 32'(cyc), 10);
        chk("t3_init", 2, 32'(io[2]), 32'h0001);
        chk("t3_lut_a_hi", 2, 32'(la[2][3:1]), 0);

        // INIT differs from expected
        lut_init[0] = 16'h1235; ex[0] = 16'h1234;
        pulse_start(0); wait_done(0, cyc);
        chk("t4_init", 0, 32'(io[0]), 32'h1235);
        chk("t4_match", 0, 32'(mt[0]), 0);
        repeat (3) @(negedge C);
        chk("t4_hold", 0, 32'(io[0]), 32'h1235);

        // second start mid-run is ignored
        lut_init[1] = 16'h0006; ex[1] = 16'h0000;
        pulse_start(1);
        repeat (4) @(negedge C);
        st[1] = 1'b1; @(negedge C); st[1] = 1'b0;
        cyc = 5;
        while (dn[1] !== 1'b1 && cyc < 400) begin
            @(negedge C); cyc++;
        end
        chk("t5_cycles", 1, 32'(cyc), 12);
        chk("t5_init", 1, 32'(io[1]), 32'h0006);
        ndone = 0;
        repeat (20) begin
            @(negedge C);
            if (dn[1] === 1'b1) ndone++;
        end
        chk("t5_extra_done", 1, 32'(ndone), 0);

        // start held high across DONE re-arms after one IDLE cycle
        st[1] = 1'b1; @(negedge C);
        wait_done(1, cyc);
        @(negedge C);
        chk("t6_idle_gap", 1, 32'(bz[1]), 0);
        @(negedge C);
        chk("t6_rearm", 1, 32'(bz[1]), 1);
        st[1] = 1'b0;
        wait_done(1, cyc);
        chk("t6_cycles", 1, 32'(cyc), 12);

        // async reset mid-run
        lut_init[0] = 16'h1235; ex[0] = 16'h1235;
        pulse_start(0);
        repeat (9) @(negedge C);
        #2 R = 1'b1;
        #1;
        chk("t7_busy", 0, 32'(bz[0]), 0);
        chk("t7_lut_a", 0, 32'(la[0]), 0);
        chk("t7_init", 0, 32'(io[0]), 0);
        repeat (2) @(negedge C);
        R = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge C);
            if (dn[0] === 1'b1) ndone++;
        end
        chk("t7_no_done", 0, 32'(ndone), 0);
        pulse_start(0); wait_done(0, cyc);
        chk("t7_cycles", 0, 32'(cyc), 32);
        chk("t7_init_after", 0, 32'(io[0]), 32'h1235);
        chk("t7_match", 0, 32'(mt[0]), 32'(CHECK_EN));

        repeat (3) @(negedge C);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
